wash_timer_disp: RTL and testbench

Step timer and display encoder for the washing-machine controller. It takes the controller state, selected mode and weight, and produces three things: a per-step countdown with a one-cycle done pulse, the water-level readout, and a packed 32-bit nibble word for the seven-segment driver. It sits beside the main washer FSM on the same clock. The FSM advances a step on `timer_out` and routes `display_out` to the display scanner.

---
 rtl/wash_timer_disp.sv | 81 ++++++++
 tb/tb_wash_timer_disp.sv | 133 +++++++++++++
 2 files changed

// File: rtl/wash_timer_disp.sv
// Step countdown timer plus display/water-level encoder for the washer controller.
// Optional macro WASH_WATER_LINE_EN enables the water-level readout; otherwise it reads 0x00.
module wash_timer_disp (
    input  logic        clk_N,
    input  logic        rst,
    input  logic [3:0]  state,
    input  logic [2:0]  status_mode,
    input  logic [1:0]  status_weight,
    input  logic        light_running,
    output logic        timer_out,
    output logic [3:0]  timer_set,
    output logic [7:0]  water_line,
    output logic [31:0] display_out
);

    localparam logic [3:0] ST_PAUSE = 4'd11;

    // Duration of each controller step in ticks; untimed states return 0.
    function automatic logic [3:0] step_duration(input logic [3:0] st, input logic [1:0] w);
        logic [3:0] d;
        case (st)
            4'd1, 4'd3, 4'd5, 4'd7: d = 4'd3 + {2'b00, w};
            4'd2:                   d = 4'd9;
            4'd4:                   d = 4'd3;
            4'd6:                   d = 4'd6;
            4'd8:                   d = 4'd5;
            default:                d = 4'd0;
        endcase
        return d;
    endfunction

    logic [3:0] tracked_r;
    logic [3:0] count_r;
    logic       pulse_r;
    logic       reload_s;
    logic       count_en_s;

    // PAUSE is excluded so returning from it resumes the tracked step.
    assign reload_s   = (state != ST_PAUSE) && (state != tracked_r);
    assign count_en_s = (state != ST_PAUSE) && light_running && (count_r != 4'd0);

    // Step tracking, countdown and single-cycle expiry pulse.
    always_ff @(posedge clk_N) begin
        if (rst) begin
            tracked_r <= 4'd0;
            count_r   <= 4'd0;
            pulse_r   <= 1'b0;
        end else if (reload_s) begin
            tracked_r <= state;
            count_r   <= step_duration(state, status_weight);
            pulse_r   <= 1'b0;
        end else if (count_en_s) begin
            count_r   <= count_r - 4'd1;
            pulse_r   <= (count_r == 4'd1);
        end else begin
            pulse_r   <= 1'b0;
        end
    end

    assign timer_out = pulse_r;
    assign timer_set = count_r;

`ifdef WASH_WATER_LINE_EN
    logic [3:0] eff_state_s;

    // Water level for filling/soaking steps, held through PAUSE via the tracked step.
    always_comb begin
        eff_state_s = (state == ST_PAUSE) ? tracked_r : state;
        case (eff_state_s)
            4'd1, 4'd2, 4'd5, 4'd6: water_line = {({2'b00, status_weight} + 4'd2), 4'h0};
            default:                water_line = 8'h00;
        endcase
    end
`else
    assign water_line = 8'h00;
`endif

    assign display_out = {1'b0, status_mode, 2'b00, status_weight, state, 4'h0,
                          water_line, 4'h0, timer_set};

endmodule

// File: tb/tb_wash_timer_disp.sv
// Directed-vector bench for wash_timer_disp: reset, countdown, pause/resume,
// display packing, untimed states and mid-step reset.
module tb_wash_timer_disp;

    logic        clk_N = 1'b0;
    logic        rst;
    logic [3:0]  state;
    logic [2:0]  status_mode;
    logic [1:0]  status_weight;
    logic        light_running;
    logic        timer_out;
    logic [3:0]  timer_set;
    logic [7:0]  water_line;
    logic [31:0] display_out;

    int vectors = 0;
    int miscompares = 0;

    wash_timer_disp dut (
        .clk_N        (clk_N),
        .rst          (rst),
        .state        (state),
        .status_mode  (status_mode),
        .status_weight(status_weight),
        .light_running(light_running),
        .timer_out    (timer_out),
        .timer_set    (timer_set),
        .water_line   (water_line),
        .display_out  (display_out)
    );

    always #5 clk_N = ~clk_N;

    function automatic logic [7:0] exp_wl(input logic [7:0] v);
`ifdef WASH_WATER_LINE_EN
        return v;
`else
        return 8'h00;
`endif
    endfunction

    task automatic tick();
        @(posedge clk_N);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_timer(input string tag, input logic [3:0] cnt, input logic pulse);
        check({tag, "_set"}, {28'd0, timer_set}, {28'd0, cnt});
        check({tag, "_out"}, {31'd0, timer_out}, {31'd0, pulse});
    endtask

    initial begin
        rst = 1'b1; state = 4'd0; status_mode = 3'd0; status_weight = 2'd0; light_running = 1'b0;
        tick();
        check_timer("reset", 4'd0, 1'b0);
        check("reset_disp", display_out, 32'h0000_0000);
        rst = 1'b0;

        // Countdown of state 1 with w=2
        state = 4'd1; status_weight = 2'd2; light_running = 1'b1;
        tick();
        check_timer("cd_reload", 4'd5, 1'b0);
        check("cd_water", {24'd0, water_line}, {24'd0, exp_wl(8'h40)});
        tick(); check_timer("cd_4", 4'd4, 1'b0);
        tick(); check_timer("cd_3", 4'd3, 1'b0);
        tick(); check_timer("cd_2", 4'd2, 1'b0);
        tick(); check_timer("cd_1", 4'd1, 1'b0);
        tick(); check_timer("cd_0", 4'd0, 1'b1);
        tick(); check_timer("cd_hold0", 4'd0, 1'b0);
        tick(); check_timer("cd_hold0b", 4'd0, 1'b0);

        // Pause and resume
        state = 4'd0; tick(); check_timer("p_idle", 4'd0, 1'b0);
        state = 4'd1; tick(); check_timer("p_reload", 4'd5, 1'b0);
        tick(); tick(); check_timer("p_at3", 4'd3, 1'b0);
        state = 4'd11; light_running = 1'b0;
        tick(); check_timer("p_hold_a", 4'd3, 1'b0);
        check("p_water", {24'd0, water_line}, {24'd0, exp_wl(8'h40)});
        tick(); check_timer("p_hold_b", 4'd3, 1'b0);
        light_running = 1'b1;
        tick(); check_timer("p_hold_run", 4'd3, 1'b0);
        state = 4'd1;
        tick(); check_timer("p_res_2", 4'd2, 1'b0);
        tick(); check_timer("p_res_1", 4'd1, 1'b0);
        tick(); check_timer("p_res_0", 4'd0, 1'b1);
        tick(); check_timer("p_res_after", 4'd0, 1'b0);

        // Display packing
        status_mode = 3'd2; status_weight = 2'd1; state = 4'd7;
        tick(); check_timer("d_st7", 4'd4, 1'b0);
        state = 4'd1;
        tick(); check_timer("d_st1", 4'd4, 1'b0);
        check("d_pack1", display_out, {16'h2110, exp_wl(8'h30), 8'h04});
        state = 4'd7;
        #1;
        check("d_pack7_comb", display_out, 32'h2170_0004);
        tick();
        check("d_pack7", display_out, 32'h2170_0004);
        check("d_water7", {24'd0, water_line}, 32'h0000_0000);
        tick(); check_timer("d_cnt3", 4'd3, 1'b0);

        // Untimed states
        for (int k = 0; k < 3; k++) begin
            state = (k == 0) ? 4'd0 : ((k == 1) ? 4'd9 : 4'd10);
            for (int n = 0; n < 20; n++) begin
                tick();
                check_timer("untimed", 4'd0, 1'b0);
            end
        end

        // Reset mid-step
        state = 4'd2; status_weight = 2'd0;
        tick(); check_timer("r_reload", 4'd9, 1'b0);
        tick(); tick(); tick(); check_timer("r_at6", 4'd6, 1'b0);
        rst = 1'b1;
        tick(); check_timer("r_abort", 4'd0, 1'b0);
        rst = 1'b0;
        tick(); check_timer("r_reload2", 4'd9, 1'b0);
        tick(); check_timer("r_8", 4'd8, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
